cache_direct_ctrl: RTL and testbench



---
 rtl/cache_pkg.sv | 18 +
 rtl/cache_line_array.sv | 47 ++++
 rtl/cache_direct_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cache_direct_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared widths, derived constants and controller state encoding for the direct-mapped cache.
package cache_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned INDEX_W = 3;
  localparam int unsigned TAG_W   = ADDR_W - INDEX_W;
  localparam int unsigned LINES   = 2 ** INDEX_W;

  typedef enum logic [2:0] {
    StIdle,
    StCompare,
    StMemRd,
    StMemWr,
    StResp
  } cache_state_e;

endpackage

// File: rtl/cache_line_array.sv
// Per-line valid/tag/data storage: one gated write port, asynchronous read.
module cache_line_array #(
  parameter int unsigned INDEX_W = cache_pkg::INDEX_W,
  parameter int unsigned TAG_W   = cache_pkg::TAG_W,
  parameter int unsigned DATA_W  = cache_pkg::DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               set_valid,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data
);

  localparam int unsigned LINES = 2 ** INDEX_W;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
      // A write hit keeps the line valid; only a fill needs to set it.
      if (set_valid) begin
        valid_q[wr_index] <= 1'b1;
      end
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/cache_direct_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Define CACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module cache_direct_ctrl #(
  parameter int unsigned ADDR_W  = cache_pkg::ADDR_W,
  parameter int unsigned DATA_W  = cache_pkg::DATA_W,
  parameter int unsigned INDEX_W = cache_pkg::INDEX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_hit,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef CACHE_STATS_EN
  input  logic              mem_ready,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`else
  input  logic              mem_ready
`endif
);

  import cache_pkg::*;

  localparam int unsigned TAG_W = ADDR_W - INDEX_W;

  cache_state_e state_q, state_d;

  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               wr_q;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               line_valid;
  logic [TAG_W-1:0]   line_tag;
  logic [DATA_W-1:0]  line_data;
  logic               hit;
  logic               arr_wr_en;
  logic               arr_set_valid;
  logic [DATA_W-1:0]  arr_wr_data;
  logic [DATA_W-1:0]  rdata_d;
  logic               hit_d;

  assign index = addr_q[INDEX_W-1:0];
  assign tag   = addr_q[ADDR_W-1:INDEX_W];
  assign hit   = line_valid && (line_tag == tag);

  cache_line_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) u_lines (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (arr_wr_en),
    .wr_index  (index),
    .wr_tag    (tag),
    .wr_data   (arr_wr_data),
    .set_valid (arr_set_valid),
    .rd_index  (index),
    .rd_valid  (line_valid),
    .rd_tag    (line_tag),
    .rd_data   (line_data)
  );

  always_comb begin
    state_d       = state_q;
    arr_wr_en     = 1'b0;
    arr_set_valid = 1'b0;
    arr_wr_data   = wdata_q;
    rdata_d       = cpu_rdata;
    hit_d         = cpu_hit;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          state_d = StCompare;
        end
      end
      StCompare: begin
        hit_d = hit;
        if (wr_q) begin
          // No allocate: a write miss leaves the line untouched.
          arr_wr_en = hit;
          state_d   = StMemWr;
        end else if (hit) begin
          rdata_d = line_data;
          state_d = StResp;
        end else begin
          state_d = StMemRd;
        end
      end
      StMemRd: begin
        if (mem_ready) begin
          arr_wr_en     = 1'b1;
          arr_set_valid = 1'b1;
          arr_wr_data   = mem_rdata;
          rdata_d       = mem_rdata;
          state_d       = StResp;
        end
      end
      StMemWr: begin
        if (mem_ready) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      cpu_rdata <= '0;
      cpu_hit   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpu_rdata <= rdata_d;
      cpu_hit   <= hit_d;
      if (state_q == StIdle && cpu_req) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        wr_q    <= cpu_wr;
      end
    end
  end

  // Decoded from state so an asynchronous reset drops mem_req immediately.
  assign cpu_done  = (state_q == StResp);
  assign cpu_stall = (state_q != StIdle);
  assign mem_req   = (state_q == StMemRd) || (state_q == StMemWr);
  assign mem_wr    = (state_q == StMemWr);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == StCompare) begin
      if (hit) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_direct_ctrl.sv
// Directed bench for cache_direct_ctrl with an array-based cache model and per-cycle checks.
module tb_cache_direct_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_wr;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_done, cpu_hit, cpu_stall;
  logic        mem_req, mem_wr, mem_ready;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  cache_direct_ctrl u_dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_done  (cpu_done),
    .cpu_hit   (cpu_hit),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
`ifdef CACHE_STATS_EN
    .mem_ready (mem_ready),
    .hit_count (hit_count),
    .miss_count(miss_count)
`else
    .mem_ready (mem_ready)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: eight one-word lines plus the last data returned to the CPU.
  bit          m_valid [8];
  logic [12:0] m_tag   [8];
  logic [15:0] m_data  [8];
  logic [15:0] m_rdata;
  int          m_hits, m_misses;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_data[i]  = '0;
    end
    m_rdata  = '0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic chk_ctl(input string name, input bit stall, input bit req, input bit done);
    chk({name, "_stall"}, cpu_stall, stall);
    chk({name, "_mem_req"}, mem_req, req);
    chk({name, "_done"}, cpu_done, done);
  endtask

  task automatic chk_stats(input string name);
`ifdef CACHE_STATS_EN
    chk({name, "_hit_count"}, hit_count, m_hits);
    chk({name, "_miss_count"}, miss_count, m_misses);
`else
    if (name.len() == 0) $display("unnamed stats check");
`endif
  endtask

  // One complete CPU transaction; mem answers after `waits` stall cycles with `mrdata`.
  task automatic do_op(input string name, input bit wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input int waits, input logic [15:0] mrdata);
    int          idx;
    logic [12:0] tg;
    bit          exp_hit;
    idx     = int'(addr[2:0]);
    tg      = addr[15:3];
    exp_hit = m_valid[idx] && (m_tag[idx] == tg);

    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_wr    = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    @(negedge clk);
    cpu_req   = 1'b0;
    cpu_addr  = 16'hFFFF;
    cpu_wdata = 16'hFFFF;
    chk_ctl({name, "_cmp"}, 1'b1, 1'b0, 1'b0);

    if (!wr && exp_hit) begin
      // Stray ready/data while mem_req is low must be ignored.
      mem_ready = 1'b1;
      mem_rdata = 16'hDEAD;
      @(negedge clk);
      m_rdata = m_data[idx];
      m_hits++;
    end else begin
      @(negedge clk);
      for (int w = 0; w <= waits; w++) begin
        chk_ctl({name, "_mem"}, 1'b1, 1'b1, 1'b0);
        chk({name, "_mem_wr"}, mem_wr, wr);
        chk({name, "_mem_addr"}, mem_addr, addr);
        if (wr) chk({name, "_mem_wdata"}, mem_wdata, wdata);
        if (w == waits) begin
          mem_ready = 1'b1;
          mem_rdata = mrdata;
        end
        @(negedge clk);
      end
      if (exp_hit) m_hits++;
      else m_misses++;
      if (wr) begin
        if (exp_hit) m_data[idx] = wdata;
      end else begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_data[idx]  = mrdata;
        m_rdata      = mrdata;
      end
    end
    mem_ready = 1'b0;
    mem_rdata = 16'h0000;

    chk_ctl({name, "_resp"}, 1'b1, 1'b0, 1'b1);
    chk({name, "_hit"}, cpu_hit, exp_hit);
    chk({name, "_rdata"}, cpu_rdata, m_rdata);
    @(negedge clk);
    chk_ctl({name, "_idle"}, 1'b0, 1'b0, 1'b0);
    chk_stats(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    cpu_req   = 1'b0;
    cpu_wr    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_ctl("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_rdata", cpu_rdata, 16'h0000);
    chk("reset_hit", cpu_hit, 1'b0);
    chk("reset_mem_wr", mem_wr, 1'b0);
    chk("reset_mem_addr", mem_addr, 16'h0000);
    chk("reset_mem_wdata", mem_wdata, 16'h0000);
    chk_stats("reset");
    rst = 1'b1;
    @(negedge clk);

    // 1: cold read miss
    do_op("t1_rd_miss", 1'b0, 16'h0005, 16'h0000, 3, 16'hBEEF);
    chk("t1_rdata_lit", cpu_rdata, 16'hBEEF);
    chk("t1_hit_lit", cpu_hit, 1'b0);

    // 2: read hit
    do_op("t2_rd_hit", 1'b0, 16'h0005, 16'h0000, 0, 16'h0000);
    chk("t2_rdata_lit", cpu_rdata, 16'hBEEF);
    chk("t2_hit_lit", cpu_hit, 1'b1);

    // 3: write hit then read back
    do_op("t3_wr_hit", 1'b1, 16'h0005, 16'h1234, 2, 16'h0000);
    chk("t3_wr_hit_lit", cpu_hit, 1'b1);
    do_op("t3_rd_back", 1'b0, 16'h0005, 16'h0000, 0, 16'h0000);
    chk("t3_rdata_lit", cpu_rdata, 16'h1234);

    // 4: conflicting tag on index 5 evicts 0005
    do_op("t4_rd_conf", 1'b0, 16'h000D, 16'h0000, 1, 16'hCAFE);
    chk("t4_rdata_lit", cpu_rdata, 16'hCAFE);
    do_op("t4_rd_evicted", 1'b0, 16'h0005, 16'h0000, 1, 16'h1234);
    chk("t4_hit_lit", cpu_hit, 1'b0);

    // 5: write miss does not allocate
    do_op("t5_wr_miss", 1'b1, 16'h0022, 16'h5555, 0, 16'h0000);
    chk("t5_wr_hit_lit", cpu_hit, 1'b0);
    do_op("t5_rd_after", 1'b0, 16'h0022, 16'h0000, 0, 16'h5555);
    chk("t5_rd_hit_lit", cpu_hit, 1'b0);

    // 6: asynchronous reset while waiting in a memory read
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_wr   = 1'b0;
    cpu_addr = 16'h0015;
    @(negedge clk);
    cpu_req  = 1'b0;
    @(negedge clk);
    chk_ctl("t6_pre", 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk_ctl("t6_async", 1'b0, 1'b0, 1'b0);
    chk("t6_mem_addr", mem_addr, 16'h0000);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    chk("t6_rdata", cpu_rdata, 16'h0000);
    chk_stats("t6_stats");
    do_op("t6_rd_after", 1'b0, 16'h0005, 16'h0000, 1, 16'hBEEF);
    chk("t6_hit_lit", cpu_hit, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
